// File: rtl/sw_debounce_latch.sv
// Switch/key front-end: two-flop synchronisers, debounce FSMs for the 8 switches
// and the push button, and a live/latch output register feeding the encoder X input.
module sw_debounce_latch #(
   parameter int unsigned CNT_MAX = 1_000_000,
   parameter int unsigned CW      = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sw,
   input  logic       key_n,
   input  logic       live,
   output logic [7:0] x_out,
   output logic       x_valid,
   output logic       busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   logic [7:0]    sw_meta_q, sw_s_q;
   logic          key_meta_q, key_s_q;

   state_t        sw_state_q, sw_state_d;
   logic [7:0]    stable_q, stable_d;
   logic [7:0]    sw_cand_q, sw_cand_d;
   logic [CW-1:0] sw_cnt_q, sw_cnt_d;
   logic          sw_commit_s;

   state_t        key_state_q, key_state_d;
   logic          key_db_q, key_db_d;
   logic          key_cand_q, key_cand_d;
   logic [CW-1:0] key_cnt_q, key_cnt_d;
   logic          key_press_s;

   logic [7:0]    x_out_q, x_out_d;
   logic          x_valid_q, x_valid_d;
   logic          busy_q, busy_d;

   // Switch debounce: a bounce back to the old level abandons, any further change restarts.
   always_comb begin
      sw_state_d  = sw_state_q;
      stable_d    = stable_q;
      sw_cand_d   = sw_cand_q;
      sw_cnt_d    = sw_cnt_q;
      sw_commit_s = 1'b0;
      case (sw_state_q)
         ST_IDLE: begin
            if (sw_s_q != stable_q) begin
               sw_state_d = ST_COUNT;
               sw_cnt_d   = CNT_ZERO;
               sw_cand_d  = sw_s_q;
            end else begin
               sw_state_d = ST_IDLE;
            end
         end
         ST_COUNT: begin
            if (sw_s_q == stable_q) begin
               sw_state_d = ST_IDLE;
            end else if (sw_s_q != sw_cand_q) begin
               sw_cnt_d  = CNT_ZERO;
               sw_cand_d = sw_s_q;
            end else if (sw_cnt_q == CNT_LAST) begin
               sw_commit_s = 1'b1;
               stable_d    = sw_cand_q;
               sw_state_d  = ST_IDLE;
            end else begin
               sw_cnt_d = sw_cnt_q + CNT_ONE;
            end
         end
         default: begin
            sw_state_d = ST_IDLE;
         end
      endcase
   end

   // Key debounce: same structure, 1 bit; only a 1->0 commit is a press event.
   always_comb begin
      key_state_d = key_state_q;
      key_db_d    = key_db_q;
      key_cand_d  = key_cand_q;
      key_cnt_d   = key_cnt_q;
      key_press_s = 1'b0;
      case (key_state_q)
         ST_IDLE: begin
            if (key_s_q != key_db_q) begin
               key_state_d = ST_COUNT;
               key_cnt_d   = CNT_ZERO;
               key_cand_d  = key_s_q;
            end else begin
               key_state_d = ST_IDLE;
            end
         end
         ST_COUNT: begin
            if (key_s_q == key_db_q) begin
               key_state_d = ST_IDLE;
            end else if (key_s_q != key_cand_q) begin
               key_cnt_d  = CNT_ZERO;
               key_cand_d = key_s_q;
            end else if (key_cnt_q == CNT_LAST) begin
               key_press_s = ~key_cand_q;
               key_db_d    = key_cand_q;
               key_state_d = ST_IDLE;
            end else begin
               key_cnt_d = key_cnt_q + CNT_ONE;
            end
         end
         default: begin
            key_state_d = ST_IDLE;
         end
      endcase
   end

   // Output load; stable_d already carries a same-cycle switch commit.
   always_comb begin
      x_out_d   = x_out_q;
      x_valid_d = 1'b0;
      busy_d    = (sw_state_d == ST_COUNT);
      if (live) begin
         if (sw_commit_s) begin
            x_out_d   = sw_cand_q;
            x_valid_d = 1'b1;
         end else begin
            x_valid_d = 1'b0;
         end
      end else if (key_press_s) begin
         x_out_d   = stable_d;
         x_valid_d = 1'b1;
      end else begin
         x_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_q   <= 8'h00;
         sw_s_q      <= 8'h00;
         key_meta_q  <= 1'b1;
         key_s_q     <= 1'b1;
         sw_state_q  <= ST_IDLE;
         stable_q    <= 8'h00;
         sw_cand_q   <= 8'h00;
         sw_cnt_q    <= CNT_ZERO;
         key_state_q <= ST_IDLE;
         key_db_q    <= 1'b1;
         key_cand_q  <= 1'b1;
         key_cnt_q   <= CNT_ZERO;
         x_out_q     <= 8'h00;
         x_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sw_meta_q   <= sw;
         sw_s_q      <= sw_meta_q;
         key_meta_q  <= key_n;
         key_s_q     <= key_meta_q;
         sw_state_q  <= sw_state_d;
         stable_q    <= stable_d;
         sw_cand_q   <= sw_cand_d;
         sw_cnt_q    <= sw_cnt_d;
         key_state_q <= key_state_d;
         key_db_q    <= key_db_d;
         key_cand_q  <= key_cand_d;
         key_cnt_q   <= key_cnt_d;
         x_out_q     <= x_out_d;
         x_valid_q   <= x_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign x_out   = x_out_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_sw_debounce_latch.sv
// Scoreboard bench for sw_debounce_latch: run-length reference model, directed scenarios, random phase.
module tb_sw_debounce_latch;

   localparam int CNT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic       key_n;
   logic       live;
   logic [7:0] x_out;
   logic       x_valid;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   sw_debounce_latch #(.CNT_MAX(CNT), .CW(3)) dut (
      .clk(clk), .rst(rst), .sw(sw), .key_n(key_n), .live(live),
      .x_out(x_out), .x_valid(x_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a level is accepted once the synchronised input has held the
   // same value for CNT+1 consecutive clock edges while differing from the accepted level.
   logic [7:0] s1, s2, stab = 8'h00, runval, ev, ld, xm = 8'h00;
   logic       k1, k2, kdb, krunval, ke;
   int         run, krun;
   bit         cm, kc, pr, bm = 1'b0;
   logic [7:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         s1 = 8'h00; s2 = 8'h00; k1 = 1'b1; k2 = 1'b1;
         stab = 8'h00; kdb = 1'b1; run = 0; krun = 0; xm = 8'h00; bm = 1'b0;
      end else begin
         ev = s2; ke = k2;
         if (run > 0 && ev == runval) run++;
         else begin runval = ev; run = 1; end
         if (krun > 0 && ke == krunval) krun++;
         else begin krunval = ke; krun = 1; end
         cm = (run >= CNT + 1) && (ev != stab);
         kc = (krun >= CNT + 1) && (ke != kdb);
         pr = kc && (ke == 1'b0);
         ld = cm ? ev : stab;
         if (live) begin
            if (cm) begin exp_q.push_back(ev); xm = ev; end
         end else if (pr) begin
            exp_q.push_back(ld); xm = ld;
         end
         if (cm) stab = ev;
         if (kc) kdb = ke;
         bm = (ev != stab);
         s2 = s1; s1 = sw; k2 = k1; k1 = key_n;
      end
   end

   // Monitor: every load pulse must match the oldest expected load, in the same cycle.
   logic [7:0] e;
   always @(negedge clk) begin
      check("x_valid", {31'd0, x_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (x_valid) check("load_val", {24'd0, x_out}, {24'd0, e});
      end
      check("x_out", {24'd0, x_out}, {24'd0, xm});
      check("busy", {31'd0, busy}, {31'd0, bm});
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns the edge index (1-based) of the first x_valid pulse and the number of pulses.
   task automatic watch(input int n, output int first, output int pulses, output int busy_seen);
      first = 0; pulses = 0; busy_seen = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (x_valid) begin
            pulses++;
            if (first == 0) first = i;
         end
         if (busy) busy_seen = 1;
      end
   endtask

   int first, pulses, bsy, seen01;

   initial begin
      rst = 1'b1; sw = 8'hA5; key_n = 1'b1; live = 1'b1;
      // 1: reset, then live-mode commit on edge 7
      tick(3);
      check("rst_x_out", {24'd0, x_out}, 32'h0);
      check("rst_x_valid", {31'd0, x_valid}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      rst = 1'b0;
      watch(12, first, pulses, bsy);
      check("s1_edge", first, 7);
      check("s1_pulses", pulses, 1);
      check("s1_x_out", {24'd0, x_out}, 32'hA5);

      // 2: bounce rejection from 00
      sw = 8'h00; tick(12);
      sw = 8'h10; tick(3);
      sw = 8'h00;
      watch(12, first, pulses, bsy);
      check("s2_pulses", pulses, 0);
      check("s2_busy_seen", bsy, 1);
      check("s2_busy_end", {31'd0, busy}, 32'h0);
      check("s2_x_out", {24'd0, x_out}, 32'h00);

      // 3: restart on change two cycles after COUNT entry
      sw = 8'h01; seen01 = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (x_out == 8'h01) seen01 = 1; end
      sw = 8'h03;
      for (int i = 0; i < 15; i++) begin @(negedge clk); if (x_out == 8'h01) seen01 = 1; end
      check("s3_never01", seen01, 0);
      check("s3_x_out", {24'd0, x_out}, 32'h03);

      // 4: latch mode, bouncy key then hold
      live = 1'b0; sw = 8'h80;
      watch(12, first, pulses, bsy);
      check("s4_no_load", pulses, 0);
      check("s4_hold", {24'd0, x_out}, 32'h03);
      key_n = 1'b0; tick(1); key_n = 1'b1; tick(1);
      key_n = 1'b0; tick(1); key_n = 1'b1; tick(1);
      key_n = 1'b0;
      watch(12, first, pulses, bsy);
      check("s4_edge", first, 7);
      check("s4_pulses", pulses, 1);
      check("s4_x_out", {24'd0, x_out}, 32'h80);
      key_n = 1'b1;
      watch(12, first, pulses, bsy);
      check("s4_release", pulses, 0);

      // 5: switch commit and key press on the same edge
      sw = 8'h42; key_n = 1'b0;
      watch(12, first, pulses, bsy);
      check("s5_edge", first, 7);
      check("s5_pulses", pulses, 1);
      check("s5_x_out", {24'd0, x_out}, 32'h42);
      key_n = 1'b1; tick(10);

      // 6: reset at cnt = 2 while counting towards FF
      live = 1'b1; sw = 8'hFF;
      tick(5);
      rst = 1'b1; tick(2);
      check("s6_rst_x_out", {24'd0, x_out}, 32'h0);
      check("s6_rst_busy", {31'd0, busy}, 32'h0);
      check("s6_rst_valid", {31'd0, x_valid}, 32'h0);
      rst = 1'b0;
      watch(12, first, pulses, bsy);
      check("s6_edge", first, 7);
      check("s6_x_out", {24'd0, x_out}, 32'hFF);

      // Random phase: mixes bounces, long holds, key activity and mode changes
      for (int seg = 0; seg < 600; seg++) begin
         if ($urandom_range(0, 9) == 0) live = $urandom_range(0, 1);
         if ($urandom_range(0, 2) != 0) sw = 8'($urandom);
         if ($urandom_range(0, 2) == 0) key_n = ~key_n;
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1; tick($urandom_range(1, 3)); rst = 1'b0;
         end
         tick($urandom_range(0, 1) ? $urandom_range(1, CNT) : $urandom_range(CNT + 1, 3 * CNT));
      end
      tick(20);
      check("drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
